// File: rtl/lagarto_l15_buf_pkg.sv
// Shared types and helpers for the Lagarto L1.5 request buffer.
package lagarto_l15_buf_pkg;

  localparam int unsigned OutCntWidth = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } buf_state_e;

  // Evictions and interrupts are unsolicited; every other return retires a request.
  function automatic logic is_completion(input wt_cache_pkg::l15_rtrntypes_t rtype);
    return (rtype != wt_cache_pkg::L15_EVICT_REQ) && (rtype != wt_cache_pkg::L15_INT_RET);
  endfunction

endpackage

// File: rtl/wt_cache_pkg.sv
// L1.5 request/return message types shared between the core-side cache and the OpenPiton L1.5.
// Reduced field set: only what the core request path and return path carry here.
package wt_cache_pkg;

  localparam int unsigned L15_TID_WIDTH = 2;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_ATOMIC_RQ = 5'b00110,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    L15_LOAD_RET   = 4'b0000,
    L15_IFILL_RET  = 4'b0001,
    L15_EVICT_REQ  = 4'b0011,
    L15_ST_ACK     = 4'b0100,
    L15_INT_RET    = 4'b0111,
    L15_ATOMIC_RET = 4'b1110
  } l15_rtrntypes_t;

  typedef struct packed {
    logic                     l15_val;
    l15_reqtypes_t            l15_rqtype;
    logic                     l15_nc;
    logic [2:0]               l15_size;
    logic [L15_TID_WIDTH-1:0] l15_threadid;
    logic [39:0]              l15_address;
    logic [63:0]              l15_data;
    logic [3:0]               l15_amo_op;
  } l15_req_t;

  typedef struct packed {
    logic                     l15_ack;
    logic                     l15_header_ack;
    logic                     l15_val;
    l15_rtrntypes_t           l15_returntype;
    logic [1:0]               l15_error;
    logic                     l15_noncacheable;
    logic [L15_TID_WIDTH-1:0] l15_threadid;
    logic [63:0]              l15_data_0;
    logic [63:0]              l15_data_1;
  } l15_rtrn_t;

endpackage

// File: rtl/lagarto_l15_req_fifo.sv
// Synchronous FIFO of L1.5 requests; occupancy counter disambiguates full from empty.
module lagarto_l15_req_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  l15_req_t               data_i,
  input  logic                   pop_i,
  output l15_req_t               data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  l15_req_t            mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/lagarto_l15_req_buffer.sv
// Elastic request buffer between the Lagarto core and the OpenPiton L1.5 with drain/quiesce.
// Optional perf counters (stall_cycles_o, max_occ_o) exist when LAGARTO_L15_BUF_PERF_EN is defined.
module lagarto_l15_req_buffer
  import wt_cache_pkg::*;
  import lagarto_l15_buf_pkg::*;
#(
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  l15_req_t               core_req_i,
  output l15_rtrn_t              core_rtrn_o,
  output l15_req_t               l15_req_o,
  input  l15_rtrn_t              l15_rtrn_i,
  input  logic                   drain_i,
  output logic                   idle_o,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic [OutCntWidth-1:0] outstanding_o,
  output logic                   err_o
`ifdef LAGARTO_L15_BUF_PERF_EN
  ,
  output logic [31:0]            stall_cycles_o,
  output logic [$clog2(Depth):0] max_occ_o
`endif
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  buf_state_e             state_q, state_d;
  logic                   idle_q, idle_d;
  logic [OutCntWidth-1:0] outst_q, outst_d;
  logic                   err_q, err_d;

  l15_req_t               head;
  logic                   full, empty;
  logic [CntW-1:0]        occ;
  logic                   can_accept, push, pop, issue_val;
  logic                   completion, inc, dec;

  lagarto_l15_req_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (core_req_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      idle_q  <= 1'b0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Leaving drain takes priority over reaching idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_i) state_d = DRAIN;
      DRAIN: begin
        if (!drain_i)                       state_d = RUN;
        else if (empty && (outst_q == '0))  state_d = IDLE;
      end
      IDLE:    if (!drain_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    can_accept = (state_q == RUN) && !full;
    idle_d     = (state_d == IDLE);
  end

  assign push      = core_req_i.l15_val && can_accept;
  assign issue_val = !empty && (outst_q < OutCntWidth'(MaxOutstanding));
  assign pop       = issue_val && l15_rtrn_i.l15_ack;

  always_comb begin
    l15_req_o = '0;
    if (!empty) l15_req_o = head;
    l15_req_o.l15_val = issue_val;
  end

  always_comb begin
    core_rtrn_o                = l15_rtrn_i;
    core_rtrn_o.l15_ack        = push;
    core_rtrn_o.l15_header_ack = push;
  end

  // A completion with nothing in flight is a protocol error and must not underflow.
  always_comb begin
    completion = l15_rtrn_i.l15_val && is_completion(l15_rtrn_i.l15_returntype);
    inc        = pop;
    dec        = completion && (outst_q != '0);
    outst_d    = outst_q;
    err_d      = err_q;
    case ({inc, dec})
      2'b10:   outst_d = outst_q + OutCntWidth'(1);
      2'b01:   outst_d = outst_q - OutCntWidth'(1);
      default: outst_d = outst_q;
    endcase
    if (completion && (outst_q == '0))        err_d = 1'b1;
    if (l15_rtrn_i.l15_ack && !issue_val)     err_d = 1'b1;
  end

  assign idle_o        = idle_q;
  assign occupancy_o   = occ;
  assign outstanding_o = outst_q;
  assign err_o         = err_q;

`ifdef LAGARTO_L15_BUF_PERF_EN
  logic [31:0]     stall_q, stall_d;
  logic [CntW-1:0] max_occ_q, max_occ_d;

  always_comb begin
    stall_d   = stall_q;
    max_occ_d = max_occ_q;
    if (core_req_i.l15_val && !push && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (occ > max_occ_q) max_occ_d = occ;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q   <= '0;
      max_occ_q <= '0;
    end else begin
      stall_q   <= stall_d;
      max_occ_q <= max_occ_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign max_occ_o      = max_occ_q;
`endif

endmodule

// File: tb/tb_lagarto_l15_req_buffer.sv
// Directed self-checking bench for lagarto_l15_req_buffer (Depth=4, MaxOutstanding=2).
module tb_lagarto_l15_req_buffer;
  import wt_cache_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  l15_req_t    core_req;
  l15_rtrn_t   core_rtrn;
  l15_req_t    l15_req;
  l15_rtrn_t   l15_rtrn;
  logic        drain;
  logic        idle;
  logic [2:0]  occ;
  logic [7:0]  outst;
  logic        err;
`ifdef LAGARTO_L15_BUF_PERF_EN
  logic [31:0] stall_cycles;
  logic [2:0]  max_occ;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  lagarto_l15_req_buffer #(
    .Depth          (4),
    .MaxOutstanding (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .core_req_i     (core_req),
    .core_rtrn_o    (core_rtrn),
    .l15_req_o      (l15_req),
    .l15_rtrn_i     (l15_rtrn),
    .drain_i        (drain),
    .idle_o         (idle),
    .occupancy_o    (occ),
    .outstanding_o  (outst),
    .err_o          (err)
`ifdef LAGARTO_L15_BUF_PERF_EN
    ,
    .stall_cycles_o (stall_cycles),
    .max_occ_o      (max_occ)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic l15_req_t mk_req(input logic [39:0] addr);
    l15_req_t r;
    r              = '0;
    r.l15_val      = 1'b1;
    r.l15_rqtype   = L15_LOAD_RQ;
    r.l15_size     = 3'b011;
    r.l15_threadid = 2'd1;
    r.l15_address  = addr;
    r.l15_data     = {24'h5a5a5a, addr};
    return r;
  endfunction

  function automatic l15_rtrn_t mk_ret(input l15_rtrntypes_t t, input logic [63:0] d);
    l15_rtrn_t r;
    r                = '0;
    r.l15_val        = 1'b1;
    r.l15_returntype = t;
    r.l15_data_0     = d;
    return r;
  endfunction

  l15_req_t exp_req;

  initial begin
    core_req = '0;
    l15_rtrn = '0;
    drain    = 1'b0;

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_occ", 128'(occ), 128'd0);
    chk("rst_outst", 128'(outst), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_idle", 128'(idle), 128'd0);
    chk("rst_l15_val", 128'(l15_req.l15_val), 128'd0);
    chk("rst_core_ack", 128'(core_rtrn.l15_ack), 128'd0);

    // Single load
    tick();
    exp_req  = mk_req(40'h00_8000_0040);
    core_req = exp_req;
    #1;
    chk("ld_core_ack", 128'(core_rtrn.l15_ack), 128'd1);
    chk("ld_core_hdr_ack", 128'(core_rtrn.l15_header_ack), 128'd1);
    chk("ld_no_bypass", 128'(l15_req.l15_val), 128'd0);
    tick();
    core_req = '0;
    #1;
    chk("ld_issue_req", 128'(l15_req), 128'(exp_req));
    chk("ld_occ1", 128'(occ), 128'd1);
    l15_rtrn.l15_ack = 1'b1;
    tick();
    l15_rtrn = '0;
    #1;
    chk("ld_outst1", 128'(outst), 128'd1);
    chk("ld_popped", 128'(occ), 128'd0);
    l15_rtrn = mk_ret(L15_LOAD_RET, 64'hdead_beef_cafe_f00d);
    #1;
    chk("ld_ret_val", 128'(core_rtrn.l15_val), 128'd1);
    chk("ld_ret_data", 128'(core_rtrn.l15_data_0), 128'h0dead_beef_cafe_f00d);
    tick();
    l15_rtrn = '0;
    #1;
    chk("ld_outst0", 128'(outst), 128'd0);
    chk("ld_err0", 128'(err), 128'd0);

    // Backpressure: four fill the FIFO, fifth waits
    for (int i = 0; i < 4; i++) begin
      core_req = mk_req(40'h1000 + 40'(i * 'h40));
      #1;
      chk($sformatf("bp_ack%0d", i), 128'(core_rtrn.l15_ack), 128'd1);
      tick();
    end
    core_req = mk_req(40'h1100);
    #1;
    chk("bp_5th_held", 128'(core_rtrn.l15_ack), 128'd0);
    chk("bp_occ4", 128'(occ), 128'd4);
    l15_rtrn.l15_ack = 1'b1;
    #1;
    chk("bp_no_full_bypass", 128'(core_rtrn.l15_ack), 128'd0);
    tick();
    l15_rtrn = '0;
    #1;
    chk("bp_5th_acked", 128'(core_rtrn.l15_ack), 128'd1);
    chk("bp_occ3", 128'(occ), 128'd3);
    chk("bp_outst1", 128'(outst), 128'd1);
    chk("bp_head_addr", 128'(l15_req.l15_address), 128'h1040);
    tick();
    core_req = '0;
    #1;
    chk("bp_occ4_again", 128'(occ), 128'd4);

    // Reset mid-operation discards everything
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_occ", 128'(occ), 128'd0);
    chk("mid_rst_outst", 128'(outst), 128'd0);
    chk("mid_rst_l15_val", 128'(l15_req.l15_val), 128'd0);

    // Outstanding cap of 2 with three queued
    for (int i = 0; i < 3; i++) begin
      core_req = mk_req(40'h100 + 40'(i * 'h40));
      tick();
    end
    core_req = '0;
    l15_rtrn.l15_ack = 1'b1;
    tick();
    tick();
    l15_rtrn = '0;
    #1;
    chk("cap_val_drop", 128'(l15_req.l15_val), 128'd0);
    chk("cap_occ1", 128'(occ), 128'd1);
    chk("cap_outst2", 128'(outst), 128'd2);
    l15_rtrn = mk_ret(L15_ST_ACK, 64'h0);
    tick();
    l15_rtrn = '0;
    #1;
    chk("cap_outst1", 128'(outst), 128'd1);
    chk("cap_val_back", 128'(l15_req.l15_val), 128'd1);
    chk("cap_head_addr", 128'(l15_req.l15_address), 128'h180);

    // Simultaneous issue and completion, then non-completing returns
    l15_rtrn = mk_ret(L15_LOAD_RET, 64'h1);
    l15_rtrn.l15_ack = 1'b1;
    tick();
    l15_rtrn = '0;
    #1;
    chk("sim_outst", 128'(outst), 128'd1);
    chk("sim_occ0", 128'(occ), 128'd0);
    l15_rtrn = mk_ret(L15_EVICT_REQ, 64'h2);
    tick();
    l15_rtrn = mk_ret(L15_INT_RET, 64'h3);
    tick();
    l15_rtrn = '0;
    #1;
    chk("evict_int_outst", 128'(outst), 128'd1);
    chk("evict_int_err", 128'(err), 128'd0);

    // Drain: two in flight, one queued
    core_req = mk_req(40'h200);
    #1;
    chk("dr_x_ack", 128'(core_rtrn.l15_ack), 128'd1);
    tick();
    core_req = mk_req(40'h240);
    l15_rtrn.l15_ack = 1'b1;
    tick();
    core_req = '0;
    l15_rtrn = '0;
    #1;
    chk("dr_outst2", 128'(outst), 128'd2);
    chk("dr_occ1", 128'(occ), 128'd1);
    drain = 1'b1;
    tick();
    core_req = mk_req(40'h280);
    #1;
    chk("dr_no_ack", 128'(core_rtrn.l15_ack), 128'd0);
    l15_rtrn = mk_ret(L15_ST_ACK, 64'h0);
    tick();
    l15_rtrn = '0;
    #1;
    chk("dr_keeps_issuing", 128'(l15_req.l15_val), 128'd1);
    l15_rtrn.l15_ack = 1'b1;
    tick();
    l15_rtrn = mk_ret(L15_ST_ACK, 64'h0);
    tick();
    tick();
    l15_rtrn = '0;
    #1;
    chk("dr_outst0", 128'(outst), 128'd0);
    chk("dr_not_idle_yet", 128'(idle), 128'd0);
    tick();
    chk("dr_idle", 128'(idle), 128'd1);
    chk("dr_idle_no_ack", 128'(core_rtrn.l15_ack), 128'd0);
    drain = 1'b0;
    #1;
    chk("dr_release_same_cyc", 128'(core_rtrn.l15_ack), 128'd0);
    tick();
    chk("dr_idle_off", 128'(idle), 128'd0);
    chk("dr_run_ack", 128'(core_rtrn.l15_ack), 128'd1);
    tick();
    core_req = '0;

    // Error: completion with nothing outstanding, sticky
    l15_rtrn = mk_ret(L15_LOAD_RET, 64'h0);
    tick();
    l15_rtrn = '0;
    #1;
    chk("err_set", 128'(err), 128'd1);
    chk("err_outst_hold0", 128'(outst), 128'd0);
    tick();
    chk("err_sticky", 128'(err), 128'd1);
    core_req = mk_req(40'h300);
    tick();
    core_req = mk_req(40'h340);
    tick();
    core_req = '0;
    #1;
    chk("err_occ3", 128'(occ), 128'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst3_occ", 128'(occ), 128'd0);
    chk("rst3_l15_val", 128'(l15_req.l15_val), 128'd0);
    chk("rst3_err", 128'(err), 128'd0);

    // Error: L1.5 ack while nothing is offered
    l15_rtrn.l15_ack = 1'b1;
    tick();
    l15_rtrn = '0;
    #1;
    chk("err_spurious_ack", 128'(err), 128'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // Drain from already-empty: idle two cycles after drain rises
    drain = 1'b1;
    tick();
    chk("de_idle_c1", 128'(idle), 128'd0);
    tick();
    chk("de_idle_c2", 128'(idle), 128'd1);
    drain = 1'b0;
    tick();
    chk("de_idle_off", 128'(idle), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
